// File: rtl/alu_decoder_mc.sv
// ALU control decoder with an iterative shift-add multiplier.
// MUL stalls the datapath for WIDTH+1 cycles, then pulses result_valid.
module alu_decoder_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       ALU_OP,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       ALU_control,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] mul_lo,
  output logic [WIDTH-1:0] mul_hi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CW-1:0]      cnt;
  logic               is_mul;
  logic               start;
  logic               last;
  logic               rtype;

  assign rtype = (ALU_OP == 2'b10);

  always_comb begin
    ALU_control = 3'b010;
    unique case (1'b1)
      ALU_OP == 2'b01:
        ALU_control = 3'b100;
      rtype && funct == 6'b100010:
        ALU_control = 3'b100;
      rtype && funct == 6'b101010:
        ALU_control = 3'b110;
      rtype && funct == 6'b011100:
        ALU_control = 3'b101;
      rtype && funct == 6'b100100:
        ALU_control = 3'b000;
      rtype && funct == 6'b100101:
        ALU_control = 3'b001;
      default:
        ALU_control = 3'b010;
    endcase
  end

  assign is_mul  = (ALU_control == 3'b101);
  assign start   = valid_in && is_mul;
  assign last    = (cnt == CW'(WIDTH - 1));
  assign acc_sum = acc + (b_reg[0] ? a_reg : '0);

  assign busy         = (state == IDLE && start)
                     || (state == MUL);
  assign result_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = MUL;
      MUL:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_hi <= '0;
      mul_lo <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= {{WIDTH{1'b0}}, src_a};
            b_reg <= src_b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          acc   <= acc_sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          // final partial sum goes straight to the outputs
          if (last) {mul_hi, mul_lo} <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_decoder_mc.sv
// Directed bench for alu_decoder_mc: decode table sweep,
// multiply latency, reset abort and WIDTH=8 back-to-back issue.
module tb_alu_decoder_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid32;
  logic        valid8;
  logic [1:0]  op;
  logic [5:0]  fn;
  logic [31:0] sa;
  logic [31:0] sb;
  logic [7:0]  sa8;
  logic [7:0]  sb8;
  logic [2:0]  ctl32;
  logic        busy32;
  logic        rv32;
  logic [31:0] lo32;
  logic [31:0] hi32;
  logic [2:0]  ctl8;
  logic        busy8;
  logic        rv8;
  logic [7:0]  lo8;
  logic [7:0]  hi8;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] F_MUL = 6'b011100;

  always #5 clk = ~clk;

  alu_decoder_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .valid_in(valid32),
    .ALU_OP(op), .funct(fn),
    .src_a(sa), .src_b(sb),
    .ALU_control(ctl32), .busy(busy32),
    .result_valid(rv32),
    .mul_lo(lo32), .mul_hi(hi32)
  );

  alu_decoder_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .valid_in(valid8),
    .ALU_OP(op), .funct(fn),
    .src_a(sa8), .src_b(sb8),
    .ALU_control(ctl8), .busy(busy8),
    .result_valid(rv8),
    .mul_lo(lo8), .mul_hi(hi8)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mul32(input string nm,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [63:0] exp,
                       input bit scramble);
    int n;
    valid32 = 1'b1;
    op = 2'b10;
    fn = F_MUL;
    sa = a;
    sb = b;
    #1;
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      tick();
      valid32 = 1'b0;
      op = 2'b00;
      fn = 6'b000000;
      if (scramble) begin
        sa = $urandom;
        sb = $urandom;
      end
      #1;
    end
    check({nm, " busy_cycles"}, 64'(n), 64'd33);
    check({nm, " rv"}, 64'(rv32), 64'd1);
    check({nm, " product"}, {hi32, lo32}, exp);
    tick();
    check({nm, " rv_end"}, 64'(rv32), 64'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] ctl;
  } dec_t;

  initial begin
    dec_t        vec[32];
    logic [1:0]  ops[4];
    logic [5:0]  fs[8];
    logic [2:0]  rexp[8];
    int          n;
    int          pulses;
    int          pos[4];

    ops  = '{2'b00, 2'b01, 2'b10, 2'b11};
    fs   = '{6'b100000, 6'b100010, 6'b101010,
             6'b011100, 6'b100100, 6'b100101,
             6'b000000, 6'b111111};
    rexp = '{3'b010, 3'b100, 3'b110, 3'b101,
             3'b000, 3'b001, 3'b010, 3'b010};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        vec[i*8+j] = '{ops[i], fs[j],
          ops[i] == 2'b10 ? rexp[j] :
          ops[i] == 2'b01 ? 3'b100 : 3'b010};

    rst = 1'b1;
    valid32 = 1'b0;
    valid8 = 1'b0;
    op = 2'b00;
    fn = 6'b000000;
    sa = '0;
    sb = '0;
    sa8 = '0;
    sb8 = '0;
    tick();
    tick();
    check("rst busy32", 64'(busy32), 64'd0);
    check("rst rv32", 64'(rv32), 64'd0);
    check("rst prod32", {hi32, lo32}, 64'd0);
    check("rst busy8", 64'(busy8), 64'd0);
    check("rst rv8", 64'(rv8), 64'd0);
    check("rst prod8", 64'({hi8, lo8}), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) begin
      op = vec[i].op;
      fn = vec[i].fn;
      valid32 = (vec[i].ctl != 3'b101);
      #1;
      check($sformatf("dec op=%b fn=%b", op, fn),
            64'(ctl32), 64'(vec[i].ctl));
      check("dec busy", 64'(busy32), 64'd0);
      tick();
    end
    valid32 = 1'b0;
    check("dec rv", 64'(rv32), 64'd0);
    tick();

    mul32("m7x6", 32'd7, 32'd6, 64'd42, 1'b0);

    // abort a multiply in cycle 10
    valid32 = 1'b1;
    op = 2'b10;
    fn = F_MUL;
    sa = 32'd11;
    sb = 32'd13;
    #1;
    check("abort issue busy", 64'(busy32), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      valid32 = 1'b0;
      op = 2'b00;
    end
    check("abort c10 busy", 64'(busy32), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort busy", 64'(busy32), 64'd0);
    check("abort rv", 64'(rv32), 64'd0);
    check("abort prod", {hi32, lo32}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (rv32 || busy32) pulses++;
      tick();
    end
    check("abort no_pulse", 64'(pulses), 64'd0);

    mul32("m3x5", 32'd3, 32'd5, 64'd15, 1'b0);
    mul32("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          64'hFFFF_FFFE_0000_0001, 1'b1);
    sa = '0;
    sb = '0;
    mul32("m0", 32'd0, 32'h1234_5678, 64'd0, 1'b0);

    valid32 = 1'b1;
    op = 2'b10;
    fn = 6'b100000;
    sa = 32'd9;
    sb = 32'd9;
    #1;
    check("add busy", 64'(busy32), 64'd0);
    tick();
    check("add busy_next", 64'(busy32), 64'd0);
    check("add rv", 64'(rv32), 64'd0);
    check("add prod", {hi32, lo32}, 64'd0);
    valid32 = 1'b0;
    tick();

    // WIDTH=8: hold issue high, expect a product every 10 cycles
    valid8 = 1'b1;
    op = 2'b10;
    fn = F_MUL;
    sa8 = 8'hFF;
    sb8 = 8'h02;
    #1;
    n = 0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 10 && busy8) n++;
      if (rv8) begin
        if (pulses < 4) pos[pulses] = c;
        pulses++;
        check("w8 prod", 64'({hi8, lo8}), 64'h01FE);
      end
      tick();
    end
    valid8 = 1'b0;
    check("w8 busy_cycles", 64'(n), 64'd9);
    check("w8 pulses", 64'(pulses), 64'd4);
    if (pulses == 4) begin
      check("w8 first", 64'(pos[0]), 64'd9);
      check("w8 gap1", 64'(pos[1] - pos[0]), 64'd10);
      check("w8 gap2", 64'(pos[2] - pos[1]), 64'd10);
      check("w8 gap3", 64'(pos[3] - pos[2]), 64'd10);
    end
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decoder_mc.md
# alu_decoder_mc

Parametrised successor of the single-cycle ALU decoder. It decodes `ALU_OP`/`funct` into the 3-bit `ALU_control` word combinationally, and adds AND/OR decoding. It also adds an iterative shift-add unsigned multiplier, a small FSM that stalls the datapath while a MUL executes. It sits between the main control unit and the ALU/writeback mux of the MIPS datapath.

## Interface
Parameters:
- `WIDTH`, 32: operand width; multiply takes `WIDTH` iteration cycles.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  instruction in decode/execute is valid this cycle.
- `ALU_OP`  in  2  from main control.
- `funct`  in  6  instruction funct field.
- `src_a`  in  WIDTH  multiplicand (rs value).
- `src_b`  in  WIDTH  multiplier (rt value).
- `ALU_control`  out  3  decoded ALU operation (combinational).
- `busy`  out  1  stall request to PC/pipeline registers.
- `result_valid`  out  1  one-cycle pulse, product available.
- `mul_lo`  out  WIDTH  low half of last product (registered).
- `mul_hi`  out  WIDTH  high half of last product (registered).

## Operation
- Decode, independent of FSM state:
  - `ALU_OP`=00 → 010 (add).
  - 01 → 100 (sub).
  - 11 → 010.
  - 10 → by `funct`: 100000→010, 100010→100, 101010→110, 011100→101 (MUL), 100100→000 (AND), 100101→001 (OR), any other→010.
- `is_mul` = (`ALU_control`==101).
- FSM states IDLE, MUL, DONE; reset → IDLE.
- IDLE:
  - On `valid_in && is_mul`: latch `a_reg`=`src_a` (zero-extended to 2·WIDTH), `b_reg`=`src_b`, clear accumulator (2·WIDTH) and counter; go to MUL.
  - Otherwise stay in IDLE.
- MUL, each cycle:
  - If `b_reg[0]`, then acc += `a_reg`.
  - Then `a_reg` <<= 1, `b_reg` >>= 1, count++.
  - When count==WIDTH−1, this is the last iteration: load `mul_hi`/`mul_lo` from the final accumulator value and go to DONE.
  - Counter width is clog2(WIDTH).
- DONE: `result_valid`=1; unconditionally go to IDLE. `valid_in` is ignored.
- `valid_in` and operands are ignored in MUL and DONE; the operand registers alone determine the product.
- Arithmetic: unsigned; full 2·WIDTH product, no overflow or truncation; {`mul_hi`,`mul_lo`} = `src_a`·`src_b`.
- `mul_hi`/`mul_lo` hold their value until the next MUL completes. Non-MUL instructions never alter them.
- Non-MUL instructions never leave IDLE and never assert `busy`.

## Timing
- `busy` is combinational: (IDLE && `valid_in` && `is_mul`) || MUL. It is high in the issue cycle itself, so the datapath stalls immediately.
- Cycle numbering, issue cycle = 0:
  - `busy` high in cycles 0..WIDTH (WIDTH+1 cycles).
  - DONE in cycle WIDTH+1: `busy`=0, `result_valid`=1, `mul_hi`/`mul_lo` already valid.
  - The datapath writes back and advances at the end of cycle WIDTH+1.
- Back-to-back MULs: the next MUL issues no earlier than the cycle after DONE. Minimum spacing is WIDTH+2 cycles.
- Reset values: `busy`=0 (given `rst` holds the FSM in IDLE; `busy` still follows `valid_in`&&`is_mul` combinationally, so the datapath holds `valid_in` low during reset), `result_valid`=0, `mul_hi`=`mul_lo`=0, state IDLE, counter 0, acc 0.
- Reset mid-operation (MUL or DONE): the next edge returns to IDLE, clears the outputs to 0 and discards the partial product. No `result_valid` pulse follows.
- Operands of 0 still take the full WIDTH iterations. There is no early termination.

## Test plan
- Decode sweep: every `ALU_OP`×listed funct, plus funct 000000 and 111111 → codes exactly as listed; `busy` stays 0 for all non-MUL codes.
- MUL 7×6, WIDTH=32: `busy` high for 33 cycles starting at the issue cycle; `result_valid` pulse in cycle 33; `mul_lo`=42, `mul_hi`=0.
- MUL 0xFFFFFFFF×0xFFFFFFFF → `mul_hi`=0xFFFFFFFE, `mul_lo`=0x00000001; the operand buses change randomly during MUL with no effect on the result.
- MUL 0×0x12345678 → `mul_lo`=`mul_hi`=0 after the full 33-cycle stall. A following ADD leaves the product registers at 0 with `busy`=0.
- Reset asserted in cycle 10 of a MUL → cycle 11: IDLE, all outputs 0, no `result_valid`. A fresh MUL 3×5 afterwards → `mul_lo`=15.
- WIDTH=8: MUL 0xFF×0x02 → `busy` 9 cycles, `mul_hi`=0x01, `mul_lo`=0xFE. Back-to-back MULs are spaced exactly 10 cycles apart.
